// File: rtl/i2s_dac_tx.sv
// I2S master transmitter: buffers stereo {left,right} pairs in a small FIFO and
// serialises them MSB-first in Philips framing on a divided bit clock.
module i2s_dac_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_n_i,
    input  logic                              en_i,
    input  logic [DIV_WIDTH-1:0]              div_i,
    input  logic                              flush_i,
    input  logic [2*DATA_WIDTH-1:0]           data_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_cnt_o,
    output logic                              sclk_o,
    output logic                              lrck_o,
    output logic                              dacdat_o,
    output logic                              underrun_o,
    output logic                              busy_o
);

    localparam int FW = 2 * DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int KW = $clog2(FW);

    logic [FW-1:0]        mem_r [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_r;
    logic [PW-1:0]        rd_ptr_r;
    logic [CW-1:0]        cnt_r;
    logic [DIV_WIDTH-1:0] div_q_r;
    logic [DIV_WIDTH-1:0] div_cnt_r;
    logic [KW-1:0]        k_r;
    logic [FW-1:0]        shift_r;
    logic                 sclk_r;
    logic                 lrck_r;
    logic                 dacdat_r;
    logic                 underrun_r;
    logic                 busy_r;

    logic fifo_full_s;
    logic fifo_empty_s;
    logic run_s;
    logic frame_start_s;
    logic push_s;
    logic pop_s;

    // busy_r doubles as the delayed enable, so a rise is en_i high while busy_r is low.
    assign run_s         = en_i && busy_r;
    assign fifo_full_s   = (cnt_r == CW'(FIFO_DEPTH));
    assign fifo_empty_s  = (cnt_r == {CW{1'b0}});
    assign frame_start_s = run_s && (div_cnt_r == div_q_r) && sclk_r && (k_r == {KW{1'b0}});
    assign pop_s         = frame_start_s && !fifo_empty_s;
    assign push_s        = valid_i && !fifo_full_s && !flush_i;

    assign ready_o    = !fifo_full_s;
    assign fifo_cnt_o = cnt_r;
    assign sclk_o     = sclk_r;
    assign lrck_o     = lrck_r;
    assign dacdat_o   = dacdat_r;
    assign underrun_o = underrun_r;
    assign busy_o     = busy_r;

    // Sample storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // FIFO pointers and occupancy; flush wins over a simultaneous push.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Bit clock divider and serialiser; all pad outputs move on SCLK falling edges.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_r     <= 1'b0;
            div_q_r    <= {DIV_WIDTH{1'b0}};
            div_cnt_r  <= {DIV_WIDTH{1'b0}};
            k_r        <= {KW{1'b0}};
            shift_r    <= {FW{1'b0}};
            sclk_r     <= 1'b0;
            lrck_r     <= 1'b0;
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else if (!en_i) begin
            busy_r     <= 1'b0;
            div_q_r    <= {DIV_WIDTH{1'b0}};
            div_cnt_r  <= {DIV_WIDTH{1'b0}};
            k_r        <= {KW{1'b0}};
            shift_r    <= {FW{1'b0}};
            sclk_r     <= 1'b0;
            lrck_r     <= 1'b0;
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else if (!busy_r) begin
            busy_r     <= 1'b1;
            div_q_r    <= div_i;
            div_cnt_r  <= {DIV_WIDTH{1'b0}};
            k_r        <= {KW{1'b0}};
            shift_r    <= {FW{1'b0}};
            sclk_r     <= 1'b0;
            lrck_r     <= 1'b0;
            dacdat_r   <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            if (div_cnt_r == div_q_r) begin
                div_cnt_r <= {DIV_WIDTH{1'b0}};
                sclk_r    <= ~sclk_r;
                if (sclk_r) begin
                    // The MSB of the shifter lags one slot, so at k=0 it still holds
                    // the previous frame's right LSB (zero straight after enable).
                    lrck_r   <= (k_r >= KW'(DATA_WIDTH));
                    dacdat_r <= shift_r[FW-1];
                    k_r      <= (k_r == KW'(FW - 1)) ? {KW{1'b0}} : k_r + KW'(1);
                    if (frame_start_s) begin
                        if (pop_s) begin
                            shift_r <= mem_r[rd_ptr_r];
                        end else begin
                            shift_r    <= {FW{1'b0}};
                            underrun_r <= 1'b1;
                        end
                    end else begin
                        shift_r <= {shift_r[FW-2:0], 1'b0};
                    end
                end
            end else begin
                div_cnt_r <= div_cnt_r + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Randomised bench for i2s_dac_tx: a timing-level reference model predicts FIFO,
// clock and framing behaviour; an I2S receiver decodes frames for a scoreboard.
module tb_i2s_dac_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int DIVW  = 8;
    localparam int FW    = 2 * DW;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic            en     = 1'b0;
    logic            flush  = 1'b0;
    logic            valid  = 1'b0;
    logic [DIVW-1:0] div    = '0;
    logic [FW-1:0]   data   = '0;
    logic            ready;
    logic [3:0]      cnt;
    logic            sclk;
    logic            lrck;
    logic            dacdat;
    logic            underrun;
    logic            busy;

    i2s_dac_tx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DIVW)) dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .en_i       (en),
        .div_i      (div),
        .flush_i    (flush),
        .data_i     (data),
        .valid_i    (valid),
        .ready_o    (ready),
        .fifo_cnt_o (cnt),
        .sclk_o     (sclk),
        .lrck_o     (lrck),
        .dacdat_o   (dacdat),
        .underrun_o (underrun),
        .busy_o     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: FIFO as a queue, SCLK edges and frame slots from elapsed cycles.
    logic [FW-1:0] mq[$];
    logic [FW-1:0] exp_frames[$];
    int  en_cyc = 0, d_lat = 0, cur_k = -1, sz0 = 0, exp_cnt = 0;
    bit  en_prev = 0, started = 0, m_run = 0;
    bit  exp_ur = 0, exp_sclk = 0, exp_lrck = 0, exp_busy = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete(); exp_frames.delete();
            en_prev = 0; started = 0; cur_k = -1; en_cyc = 0; d_lat = 0;
            exp_ur = 0; exp_sclk = 0; exp_lrck = 0; exp_busy = 0; exp_cnt = 0;
        end else begin
            sz0    = mq.size();
            exp_ur = 0;
            m_run  = en && en_prev;
            if (m_run) begin
                en_cyc++;
                if (en_cyc % (2 * (d_lat + 1)) == 0) begin
                    cur_k = (en_cyc / (2 * (d_lat + 1)) - 1) % FW;
                    if (cur_k == 0) begin
                        started = 1;
                        if (sz0 > 0) exp_frames.push_back(mq.pop_front());
                        else begin
                            exp_frames.push_back('0);
                            exp_ur = 1;
                        end
                    end
                end
            end else if (en) begin
                en_cyc = 0; d_lat = int'(div); cur_k = -1; started = 0;
            end else begin
                // the frame in flight when disabled never completes on the wire
                if (en_prev && started) void'(exp_frames.pop_back());
                started = 0; cur_k = -1;
            end
            if (flush) mq.delete();
            else if (valid && sz0 < DEPTH) mq.push_back(data);
            en_prev  = en;
            exp_busy = en;
            exp_sclk = m_run && ((en_cyc / (d_lat + 1)) % 2 == 1);
            exp_lrck = m_run && (cur_k >= DW);
            exp_cnt  = mq.size();
        end
    end

    // Per-cycle comparison of the control outputs against the model.
    always @(negedge clk) begin
        chk("ready", 32'(ready), 32'(exp_cnt != DEPTH));
        chk("fifo_cnt", 32'(cnt), 32'(exp_cnt));
        chk("sclk", 32'(sclk), 32'(exp_sclk));
        chk("lrck", 32'(lrck), 32'(exp_lrck));
        chk("underrun", 32'(underrun), 32'(exp_ur));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (!exp_busy) chk("dacdat_idle", 32'(dacdat), 32'd0);
    end

    // I2S receiver monitor: samples on SCLK rising edges, frame ends at lrck 1->0 slot.
    bit sclk_prev = 0, lr_prev = 0;
    int rx_n = -2;
    logic [FW-1:0] rx_word = '0;
    logic [FW-1:0] exp_word;

    always @(negedge clk) begin
        if (!rst_n || !exp_busy) begin
            rx_n = -2; lr_prev = 0; sclk_prev = 0;
        end else begin
            if (sclk && !sclk_prev) begin
                if (lr_prev && !lrck) begin
                    rx_word = {rx_word[FW-2:0], dacdat};
                    chk("frame_len", 32'(rx_n), 32'(FW - 1));
                    if (exp_frames.size() > 0) begin
                        exp_word = exp_frames.pop_front();
                        chk("frame_data", rx_word, exp_word);
                    end else begin
                        chk("frame_expected", 32'(exp_frames.size()), 32'd1);
                    end
                    rx_n = 0;
                end else if (rx_n < 0) begin
                    chk("first_bit", 32'(dacdat), 32'd0);
                    chk("first_lrck", 32'(lrck), 32'd0);
                    rx_n++;
                end else begin
                    rx_word = {rx_word[FW-2:0], dacdat};
                    rx_n++;
                end
                lr_prev = lrck;
            end
            sclk_prev = sclk;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_word(input logic [FW-1:0] w);
        valid = 1'b1; data = w; cyc(1); valid = 1'b0;
    endtask

    task automatic enable(input int d);
        div = DIVW'(d); en = 1'b1; cyc(1);
    endtask

    task automatic disable_at(input int k);
        int t;
        t = 0;
        while (cur_k != k && t < 5000) begin
            cyc(1); t++;
        end
        chk("disable_wait_k", 32'(cur_k), 32'(k));
        en = 1'b0; cyc(1);
        chk("dis_sclk", 32'(sclk), 32'd0);
        chk("dis_lrck", 32'(lrck), 32'd0);
        chk("dis_dacdat", 32'(dacdat), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        cyc(3);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; cyc(2);

        // single known frame followed by underruns and a mid-frame push
        push_word(32'hA55A_0F0F);
        enable(1);
        cyc(340);
        push_word($urandom);
        cyc(300);
        disable_at(10);

        // fill to full while disabled, then run with valid held high
        valid = 1'b1;
        repeat (12) begin data = $urandom; cyc(1); end
        chk("full_cnt", 32'(cnt), 32'd8);
        chk("full_ready", 32'(ready), 32'd0);
        div = '0; en = 1'b1;
        repeat (200) begin data = $urandom; cyc(1); end
        valid = 1'b0;
        disable_at(10);

        // flush: drops pending entries and the simultaneous push
        flush = 1'b1; cyc(1); flush = 1'b0;
        repeat (5) push_word($urandom);
        chk("fill5_cnt", 32'(cnt), 32'd5);
        valid = 1'b1; flush = 1'b1; data = $urandom; cyc(1);
        valid = 1'b0; flush = 1'b0;
        chk("flush_cnt", 32'(cnt), 32'd0);
        enable($urandom_range(0, 3));
        cyc(300);
        disable_at(10);

        // abort mid-frame, re-enable with a slower clock
        repeat (3) push_word($urandom);
        enable(1);
        disable_at(10);
        enable(3);
        cyc(600);
        disable_at(10);

        // randomised traffic
        for (int it = 0; it < 6; it++) begin
            enable($urandom_range(0, 3));
            for (int c = 0; c < 500; c++) begin
                valid = ($urandom_range(0, 29) == 0);
                flush = ($urandom_range(0, 299) == 0);
                data  = $urandom;
                cyc(1);
            end
            valid = 1'b0; flush = 1'b0;
            disable_at($urandom_range(3, 28));
        end

        // asynchronous reset mid-frame
        repeat (2) push_word($urandom);
        enable(0);
        cyc(100);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ready), 32'd1);
        chk("arst_cnt", 32'(cnt), 32'd0);
        chk("arst_sclk", 32'(sclk), 32'd0);
        chk("arst_lrck", 32'(lrck), 32'd0);
        chk("arst_dacdat", 32'(dacdat), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_underrun", 32'(underrun), 32'd0);
        en = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        push_word($urandom);
        enable(0);
        cyc(200);
        disable_at(12);
        chk("frames_left", 32'(exp_frames.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
